// File: rtl/serial_rx_package_pkg.sv
// Shared definitions for the serial package receiver: frame FSM state
// encoding and the mid-bit timer helper.
package serial_rx_package_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  // Timer value marking the middle of the start bit.
  function automatic int half_tick(input int timer_w);
    return (2 ** (timer_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/serial_rx_package_word.sv
// Serial word receiver: rx synchroniser, frame FSM and bit timer.
// Emits a one-cycle word strobe on a good stop bit and a frame-error strobe on a bad one.
module serial_rx_word
  import serial_rx_package_pkg::*;
#(
  parameter int WordWidth        = 8,
  parameter int SerialTimerWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [WordWidth-1:0] word_o,
  output logic                 word_stb_o,
  output logic                 frame_err_o,
  output logic                 start_acc_o,
  output logic                 idle_o
);

  localparam int BW = $clog2(WordWidth) + 1;
  localparam logic [SerialTimerWidth-1:0] T_HALF =
    SerialTimerWidth'(half_tick(SerialTimerWidth));
  localparam logic [SerialTimerWidth-1:0] T_FULL = '1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WordWidth - 1);

  logic [1:0]                  sync_q;
  logic                        rxs;
  logic [2:0]                  state_q, state_d;
  logic [SerialTimerWidth-1:0] timer_q, timer_d;
  logic [BW-1:0]               bit_q, bit_d;
  logic [WordWidth-1:0]        shreg_q, shreg_d;
  logic [WordWidth:0]          shift_in;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx_i};
  end

  assign rxs      = sync_q[1];
  assign shift_in = {rxs, shreg_q};

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 1'b1;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    word_stb_o  = 1'b0;
    frame_err_o = 1'b0;
    start_acc_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (!rxs) state_d = ST_START;
      end
      ST_START: begin
        if (timer_q == T_HALF) begin
          timer_d = '0;
          if (!rxs) begin
            state_d     = ST_DATA;
            bit_d       = '0;
            start_acc_o = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        // Timer wraps naturally, so each sample lands mid-bit.
        if (timer_q == T_FULL) begin
          shreg_d = shift_in[WordWidth:1];
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (timer_q == T_FULL) begin
          if (rxs) begin
            word_stb_o = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            frame_err_o = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        timer_d = '0;
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
    end
  end

  always_ff @(posedge clk) shreg_q <= shreg_d;

  assign word_o = shreg_q;
  assign idle_o = (state_q == ST_IDLE);

endmodule

// File: rtl/serial_rx_package.sv
// Serial package receiver: assembles 2**AddressWidth words per package and queues
// packages in a FWFT FIFO. Optional idle timeout: SERIAL_RX_PACKAGE_TIMEOUT_EN.
module serial_rx_package
  import serial_rx_package_pkg::*;
#(
  parameter int AddressWidth      = 2,
  parameter int WordWidth         = 8,
  parameter int SerialTimerWidth  = 8,
  parameter int QueueAddressWidth = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  rx,
  input  logic                                  pull,
  output logic [(2**AddressWidth)*WordWidth-1:0] data,
  output logic                                  valid,
  output logic                                  full,
  output logic                                  busy,
  output logic                                  frame_err,
  output logic                                  overrun
);

  localparam int PW    = (2 ** AddressWidth) * WordWidth;
  localparam int DEPTH = 2 ** QueueAddressWidth;
  localparam int QAW   = QueueAddressWidth;

  logic [WordWidth-1:0]    word;
  logic                    word_stb, word_err, start_acc, word_idle;
  logic [PW-1:0]           pkg_q, pkg_d;
  logic [AddressWidth-1:0] wcnt_q, wcnt_d;
  logic                    complete, do_push, do_pull, empty, timeout;
  logic [QAW:0]            wptr_q, rptr_q;
  logic [PW-1:0]           mem_q [DEPTH];
  logic                    frame_err_q, overrun_q;

  serial_rx_word #(
    .WordWidth       (WordWidth),
    .SerialTimerWidth(SerialTimerWidth)
  ) u_word (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx),
    .word_o     (word),
    .word_stb_o (word_stb),
    .frame_err_o(word_err),
    .start_acc_o(start_acc),
    .idle_o     (word_idle)
  );

`ifdef SERIAL_RX_PACKAGE_TIMEOUT_EN
  localparam int IW = SerialTimerWidth + 5;
  localparam logic [IW-1:0] I_LAST = IW'((2 ** (SerialTimerWidth + 4)) - 1);

  logic [IW-1:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    timeout    = 1'b0;
    if (start_acc) begin
      idle_cnt_d = '0;
    end else if (word_idle && (wcnt_q != '0)) begin
      if (idle_cnt_q == I_LAST) begin
        timeout    = 1'b1;
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idle_cnt_q <= '0;
    else     idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // First word received ends up in the MSBs after the last shift.
  assign pkg_d    = word_stb ? ((pkg_q << WordWidth) | PW'(word)) : pkg_q;
  assign complete = word_stb && (wcnt_q == '1);

  always_comb begin
    wcnt_d = wcnt_q;
    if (word_err || timeout) wcnt_d = '0;
    else if (word_stb)       wcnt_d = wcnt_q + 1'b1;
  end

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[QAW] != rptr_q[QAW]) &&
                   (wptr_q[QAW-1:0] == rptr_q[QAW-1:0]);
  assign do_pull = pull && !empty;
  assign do_push = complete && (!full || do_pull);

  always_ff @(posedge clk) pkg_q <= pkg_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q      <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wcnt_q      <= wcnt_d;
      frame_err_q <= word_err || timeout;
      overrun_q   <= complete && !do_push;
      if (do_push) begin
        mem_q[wptr_q[QAW-1:0]] <= pkg_d;
        wptr_q                 <= wptr_q + 1'b1;
      end
      if (do_pull) rptr_q <= rptr_q + 1'b1;
    end
  end

  assign data      = mem_q[rptr_q[QAW-1:0]];
  assign valid     = !empty;
  assign busy      = !word_idle || (wcnt_q != '0);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_rx_package.sv
// Directed bench for serial_rx_package with 16 clocks per bit and a 4-deep package FIFO.
module tb_serial_rx_package;

  localparam int AW  = 2;
  localparam int WW  = 8;
  localparam int STW = 4;
  localparam int QAW = 2;
  localparam int BIT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        pull = 1'b0;
  logic [31:0] data;
  logic        valid, full, busy, frame_err, overrun;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;

  typedef struct {
    logic [31:0] pkg;
    logic        exp_full;
    int          exp_ovr;
  } vec_t;

  vec_t tbl [5];

  serial_rx_package #(
    .AddressWidth     (AW),
    .WordWidth        (WW),
    .SerialTimerWidth (STW),
    .QueueAddressWidth(QAW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .pull     (pull),
    .data     (data),
    .valid    (valid),
    .full     (full),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun)   ovr_cnt  <= ovr_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_data(input logic [7:0] b);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(b[i], BIT);
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_data(b);
    hold(1'b1, BIT);
  endtask

  task automatic send_pkg(input logic [31:0] p);
    for (int i = 3; i >= 0; i--) send_frame(p[8*i +: 8]);
  endtask

  task automatic do_pull();
    pull = 1'b1;
    @(posedge clk);
    #1;
    pull = 1'b0;
  endtask

  initial begin
    int f0, o0;
    logic [7:0] w2;

    tbl[0] = '{32'h11112222, 1'b0, 0};
    tbl[1] = '{32'h33334444, 1'b0, 0};
    tbl[2] = '{32'h55556666, 1'b0, 0};
    tbl[3] = '{32'h77778888, 1'b1, 0};
    tbl[4] = '{32'h9999AAAA, 1'b1, 1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_data", data, 32'd0);
    rst = 1'b0;
    hold(1'b1, 20);

    // Normal package, with exact valid latency on the last stop bit
    send_frame(8'hDE);
    send_frame(8'hAD);
    send_frame(8'hBE);
    send_data(8'hEF);
    hold(1'b1, 10);
    chk("norm_valid_early", {31'd0, valid}, 32'd0);
    hold(1'b1, 1);
    chk("norm_valid_rise", {31'd0, valid}, 32'd1);
    chk("norm_data", data, 32'hDEADBEEF);
    hold(1'b1, 5);
    chk("norm_ferr", 32'(ferr_cnt), 32'd0);
    chk("norm_busy", {31'd0, busy}, 32'd0);
    do_pull();
    chk("norm_pulled_valid", {31'd0, valid}, 32'd0);
    do_pull();
    chk("empty_pull_valid", {31'd0, valid}, 32'd0);
    chk("empty_pull_full", {31'd0, full}, 32'd0);

    // FIFO fill and overrun, table-driven
    for (int i = 0; i < 5; i++) begin
      o0 = ovr_cnt;
      send_pkg(tbl[i].pkg);
      hold(1'b1, 4);
      chk($sformatf("fifo_full_%0d", i), {31'd0, full}, {31'd0, tbl[i].exp_full});
      chk($sformatf("fifo_ovr_%0d", i), 32'(ovr_cnt - o0), 32'(tbl[i].exp_ovr));
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fifo_valid_%0d", i), {31'd0, valid}, 32'd1);
      chk($sformatf("fifo_data_%0d", i), data, tbl[i].pkg);
      do_pull();
    end
    chk("fifo_drained_valid", {31'd0, valid}, 32'd0);
    chk("fifo_drained_full", {31'd0, full}, 32'd0);

    // Framing error: bad stop bit, line low for 3 bit times
    f0 = ferr_cnt;
    send_frame(8'h11);
    send_data(8'h22);
    hold(1'b0, 3 * BIT);
    chk("ferr_busy_break", {31'd0, busy}, 32'd1);
    chk("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
    chk("ferr_no_valid", {31'd0, valid}, 32'd0);
    hold(1'b1, BIT);
    chk("ferr_busy_released", {31'd0, busy}, 32'd0);
    send_pkg(32'hA1A2A3A4);
    hold(1'b1, 4);
    chk("ferr_next_valid", {31'd0, valid}, 32'd1);
    chk("ferr_next_data", data, 32'hA1A2A3A4);
    chk("ferr_single", 32'(ferr_cnt - f0), 32'd1);

    // Start-bit glitch: 8-clock low pulse
    f0 = ferr_cnt;
    hold(1'b0, 8);
    hold(1'b1, 2);
    chk("glitch_busy_mid", {31'd0, busy}, 32'd1);
    hold(1'b1, 20);
    chk("glitch_busy_end", {31'd0, busy}, 32'd0);
    chk("glitch_no_err", 32'(ferr_cnt - f0), 32'd0);
    chk("glitch_head_kept", data, 32'hA1A2A3A4);

    // Reset in the 5th data bit of the 2nd word, FIFO still holding a package
    w2 = 8'h66;
    send_frame(8'h55);
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(w2[i], BIT);
    hold(w2[4], 8);
    rst = 1'b1;
    rx = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    chk("mrst_valid", {31'd0, valid}, 32'd0);
    chk("mrst_full", {31'd0, full}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("mrst_overrun", {31'd0, overrun}, 32'd0);
    chk("mrst_data", data, 32'd0);
    hold(1'b1, 20);
    send_pkg(32'h01234567);
    hold(1'b1, 4);
    chk("mrst_pkg_valid", {31'd0, valid}, 32'd1);
    chk("mrst_pkg_data", data, 32'h01234567);
    do_pull();

    // Idle gap after a partial package
    f0 = ferr_cnt;
    send_frame(8'h11);
    send_frame(8'h22);
    hold(1'b1, 300);
`ifdef SERIAL_RX_PACKAGE_TIMEOUT_EN
    chk("tmo_ferr", 32'(ferr_cnt - f0), 32'd1);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    send_pkg(32'hC0C1C2C3);
    hold(1'b1, 4);
    chk("tmo_valid", {31'd0, valid}, 32'd1);
    chk("tmo_data", data, 32'hC0C1C2C3);
`else
    chk("hold_busy", {31'd0, busy}, 32'd1);
    chk("hold_no_err", 32'(ferr_cnt - f0), 32'd0);
    send_frame(8'h33);
    send_frame(8'h44);
    hold(1'b1, 4);
    chk("hold_valid", {31'd0, valid}, 32'd1);
    chk("hold_data", data, 32'h11223344);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
